// File: rtl/lvds_pkg.sv
// Shared types and width helpers for the multi-lane LVDS receive front end.
package lvds_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StTrain,
    StAligned,
    StFail
  } align_state_e;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lvds_lane_aligner.sv
// One serial lane: bit history, word extraction at the current slip, training
// counters and lock, plus sticky differential-pair sanity flag.
module lvds_lane_aligner
  import lvds_pkg::*;
#(
  parameter int unsigned                     PARALLEL_WIDTH = 8,
  parameter int unsigned                     MSB_FIRST      = 1,
  parameter logic [PARALLEL_WIDTH-1:0]       TRAIN_PATTERN  = 8'hA5,
  parameter int unsigned                     LOCK_MATCHES   = 4
) (
  input  logic                      clk_serial,
  input  logic                      reset,
  input  logic                      lvds_in_p,
  input  logic                      lvds_in_n,
  input  logic                      train_clear,
  input  logic                      train_en,
  input  logic                      word_done,
  output logic [PARALLEL_WIDTH-1:0] word,
  output logic                      lane_locked,
  output logic                      lock_next,
  output logic                      attempts_exhausted,
  output logic                      lane_diff_error
);

  localparam int unsigned W      = PARALLEL_WIDTH;
  localparam int unsigned HistW  = 2 * W;
  localparam int unsigned SlipW  = cnt_width(W - 1);
  localparam int unsigned MatchW = cnt_width(LOCK_MATCHES);
  localparam int unsigned AttW   = cnt_width(2 * W);

  localparam logic [SlipW-1:0]  SlipMax  = SlipW'(W - 1);
  localparam logic [MatchW-1:0] LockCnt  = MatchW'(LOCK_MATCHES);
  localparam logic [AttW-1:0]   AttMax   = AttW'(2 * W);

  logic [HistW-1:0]  hist_q, hist_d, hist_shifted;
  logic [W-1:0]      window;
  logic [SlipW-1:0]  slip_q, slip_d;
  logic [MatchW-1:0] match_cnt_q, match_cnt_d;
  logic [AttW-1:0]   attempts_q, attempts_d;
  logic              locked_q, locked_d;
  logic              diff_q;
  logic              match;

  // Newest bit at index 0; slip moves the window toward older bits.
  assign hist_d       = {hist_q[HistW-2:0], lvds_in_p};
  assign hist_shifted = hist_d >> slip_q;
  assign window       = hist_shifted[W-1:0];

  always_comb begin
    word = window;
    if (MSB_FIRST == 0) begin
      for (int i = 0; i < int'(W); i++) begin
        word[i] = window[W-1-i];
      end
    end
  end

  assign match = (word == TRAIN_PATTERN);

  always_comb begin
    slip_d      = slip_q;
    match_cnt_d = match_cnt_q;
    attempts_d  = attempts_q;
    locked_d    = locked_q;
    if (train_en && word_done && !locked_q) begin
      if (match) begin
        if (match_cnt_q < LockCnt) match_cnt_d = match_cnt_q + 1'b1;
        if (match_cnt_d == LockCnt) locked_d = 1'b1;
      end else begin
        match_cnt_d = '0;
        slip_d      = (slip_q == SlipMax) ? '0 : slip_q + 1'b1;
        if (attempts_q < AttMax) attempts_d = attempts_q + 1'b1;
      end
    end
  end

  assign lock_next          = locked_d;
  assign attempts_exhausted = !locked_d && (attempts_d == AttMax);
  assign lane_locked        = locked_q;
  assign lane_diff_error    = diff_q;

  always_ff @(posedge clk_serial) begin
    if (reset) begin
      hist_q <= '0;
      diff_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      if (lvds_in_p == lvds_in_n) diff_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_serial) begin
    if (reset || train_clear) begin
      slip_q      <= '0;
      match_cnt_q <= '0;
      attempts_q  <= '0;
      locked_q    <= 1'b0;
    end else begin
      slip_q      <= slip_d;
      match_cnt_q <= match_cnt_d;
      attempts_q  <= attempts_d;
      locked_q    <= locked_d;
    end
  end

endmodule

// File: rtl/lvds_multilane_deserializer.sv
// Multi-lane LVDS deserializer: shared word framing, training FSM driving
// per-lane bit-slip aligners, and gated word output.
module lvds_multilane_deserializer
  import lvds_pkg::*;
#(
  parameter int unsigned               NUM_LANES      = 4,
  parameter int unsigned               PARALLEL_WIDTH = 8,
  parameter int unsigned               MSB_FIRST      = 1,
  parameter logic [PARALLEL_WIDTH-1:0] TRAIN_PATTERN  = 8'hA5,
  parameter int unsigned               LOCK_MATCHES   = 4
) (
  input  logic                                clk_serial,
  input  logic                                reset,
  input  logic                                tx_frame_pulse,
  input  logic [NUM_LANES-1:0]                lvds_in_p,
  input  logic [NUM_LANES-1:0]                lvds_in_n,
  input  logic                                align_start,
  output logic [NUM_LANES*PARALLEL_WIDTH-1:0] deserialized_word,
  output logic                                rx_frame_pulse,
  output logic [NUM_LANES-1:0]                lane_locked,
  output logic                                align_done,
  output logic                                align_error,
  output logic [NUM_LANES-1:0]                lane_diff_error
);

  localparam int unsigned W       = PARALLEL_WIDTH;
  localparam int unsigned BitCntW = cnt_width(W);

  align_state_e state_q, state_d;

  logic [BitCntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic                   busy, word_done, emit;
  logic [NUM_LANES*W-1:0] lane_words;
  logic [NUM_LANES*W-1:0] word_q;
  logic                   rx_q;
  logic [NUM_LANES-1:0]   lock_next;
  logic [NUM_LANES-1:0]   attempts_exhausted;

  // Counter holds the number of bits still to sample; 1 means this edge takes the last.
  assign busy      = (bit_cnt_q != '0);
  assign word_done = (bit_cnt_q == BitCntW'(1));

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (busy) begin
      bit_cnt_d = bit_cnt_q - 1'b1;
    end else if (tx_frame_pulse) begin
      bit_cnt_d = BitCntW'(W);
    end
  end

  for (genvar l = 0; l < int'(NUM_LANES); l++) begin : g_lane
    lvds_lane_aligner #(
      .PARALLEL_WIDTH(PARALLEL_WIDTH),
      .MSB_FIRST     (MSB_FIRST),
      .TRAIN_PATTERN (TRAIN_PATTERN),
      .LOCK_MATCHES  (LOCK_MATCHES)
    ) u_aligner (
      .clk_serial        (clk_serial),
      .reset             (reset),
      .lvds_in_p         (lvds_in_p[l]),
      .lvds_in_n         (lvds_in_n[l]),
      .train_clear       (align_start),
      .train_en          (state_q == StTrain),
      .word_done         (word_done),
      .word              (lane_words[l*W +: W]),
      .lane_locked       (lane_locked[l]),
      .lock_next         (lock_next[l]),
      .attempts_exhausted(attempts_exhausted[l]),
      .lane_diff_error   (lane_diff_error[l])
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StTrain: begin
        if (&lock_next) begin
          state_d = StAligned;
        end else if (|attempts_exhausted) begin
          state_d = StFail;
        end
      end
      StIdle, StAligned, StFail: state_d = state_q;
      default: state_d = StIdle;
    endcase
    // A restart request overrides whatever the completing word decided.
    if (align_start) state_d = StTrain;
  end

  assign emit = word_done && (state_q != StTrain);

  always_ff @(posedge clk_serial) begin
    if (reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      rx_q      <= 1'b0;
      word_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= emit;
      word_q    <= emit ? lane_words : '0;
    end
  end

  assign rx_frame_pulse    = rx_q;
  assign deserialized_word = word_q;
  assign align_done        = (state_q == StAligned);
  assign align_error       = (state_q == StFail);

endmodule
